// File: rtl/riscv_types.sv
// riscv_types: shared L1 requester count, id width and memory request record.
package riscv_types;
  localparam int NUM_L1_REQUESTERS = 4;
  localparam int L1_ID_W = $clog2(NUM_L1_REQUESTERS);
  typedef struct packed {
    logic [31:0]        addr;
    logic               rnw;
    logic [31:0]        wdata;
    logic [L1_ID_W-1:0] id;
  } l1_mem_req_t;
endpackage

// File: rtl/l1_id_fifo.sv
// l1_id_fifo: small FIFO of requester ids for in-order read returns.
module l1_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2,
  localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr == PTR_W'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr == PTR_W'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/l1_request_arbiter.sv
// l1_request_arbiter: round-robin arbiter of L1 requesters into one registered
// memory request slot, with in-order routing of read returns by requester id.
module l1_request_arbiter
  import riscv_types::*;
#(
  parameter int NUM_REQ = NUM_L1_REQUESTERS,
  parameter int RD_DEPTH = 4,
  localparam int ID_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1,
  localparam int CW = $clog2(RD_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0][31:0] req_addr,
  input  logic [NUM_REQ-1:0]       req_rnw,
  input  logic [NUM_REQ-1:0][31:0] req_wdata,
  output logic [NUM_REQ-1:0]       req_ack,
  output logic                     mem_req_valid,
  output logic [31:0]              mem_req_addr,
  output logic                     mem_req_rnw,
  output logic [31:0]              mem_req_wdata,
  output logic [ID_W-1:0]          mem_req_id,
  input  logic                     mem_req_ready,
  input  logic                     mem_rd_valid,
  input  logic [31:0]              mem_rd_data,
  output logic [NUM_REQ-1:0]       rd_valid,
  output logic [31:0]              rd_data,
  output logic                     protocol_error
);
  l1_mem_req_t slot;
  logic [ID_W-1:0] rr_ptr, grant_idx, head;
  logic [NUM_REQ-1:0] eligible;
  logic grant_found, capture, push, pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  assign pop = mem_rd_valid && fifo_count != '0 && !rst;
  // A read may take the last FIFO entry when a return frees one this cycle.
  assign eligible = req_valid & (~req_rnw | {NUM_REQ{!fifo_full || pop}});
  always_comb begin
    grant_found = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (!grant_found && eligible[(int'(rr_ptr) + k) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
  end
  assign capture = grant_found && (!mem_req_valid || mem_req_ready) && !rst;
  assign push = capture && req_rnw[grant_idx];
  assign req_ack = capture ? NUM_REQ'(1) << grant_idx : '0;
  assign rd_valid = pop ? NUM_REQ'(1) << head : '0;
  assign rd_data = mem_rd_data;
  assign mem_req_addr = slot.addr;
  assign mem_req_rnw = slot.rnw;
  assign mem_req_wdata = slot.wdata;
  assign mem_req_id = ID_W'(slot.id);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem_req_valid <= 1'b0;
      rr_ptr <= '0;
      protocol_error <= 1'b0;
    end else begin
      if (capture) begin
        mem_req_valid <= 1'b1;
        rr_ptr <= grant_idx == ID_W'(NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
      end else if (mem_req_ready) mem_req_valid <= 1'b0;
      if (mem_rd_valid && fifo_empty) protocol_error <= 1'b1;
    end
  always_ff @(posedge clk)
    if (capture) slot <= '{addr: req_addr[grant_idx], rnw: req_rnw[grant_idx],
                           wdata: req_wdata[grant_idx], id: L1_ID_W'(grant_idx)};
  l1_id_fifo #(.DEPTH(RD_DEPTH), .WIDTH(ID_W)) u_id_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .push_data(grant_idx),
    .pop(pop),
    .pop_data(head),
    .full(fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_l1_request_arbiter.sv
// tb_l1_request_arbiter: directed checks of arbitration, stall, id routing and reset.
module tb_l1_request_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req_valid, req_rnw, req_ack, rd_valid;
  logic [3:0][31:0] req_addr, req_wdata;
  logic mem_req_valid, mem_req_rnw, mem_req_ready, mem_rd_valid, protocol_error;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rd_data, rd_data;
  logic [1:0] mem_req_id;
  int vectors = 0, miscompares = 0;
  logic [3:0] exp_rd [4];
  always #5 clk = ~clk;
  l1_request_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_rnw(req_rnw), .req_wdata(req_wdata), .req_ack(req_ack),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_rnw(mem_req_rnw), .mem_req_wdata(mem_req_wdata),
    .mem_req_id(mem_req_id), .mem_req_ready(mem_req_ready),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .protocol_error(protocol_error)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  initial begin
    req_valid = 4'h0;
    req_rnw = 4'h0;
    for (int i = 0; i < 4; i++) begin
      req_addr[i] = 32'h1000_0000 + 32'(i * 16);
      req_wdata[i] = 32'h0000_00A0 + 32'(i);
    end
    mem_req_ready = 1'b1;
    mem_rd_valid = 1'b0;
    mem_rd_data = '0;
    #1;
    chk("rst_valid", mem_req_valid, 0);
    chk("rst_ack", req_ack, 0);
    chk("rst_perr", protocol_error, 0);
    tick; tick;
    rst = 1'b0;
    #1 chk("post_rst_valid", mem_req_valid, 0);
    chk("post_rst_rd_valid", rd_valid, 0);
    // four reads, one grant per cycle in order 0..3
    req_valid = 4'hF;
    req_rnw = 4'hF;
    for (int i = 0; i < 4; i++) begin
      #1 chk("rr_ack", req_ack, 64'(4'b0001 << i));
      tick;
      req_valid[i] = 1'b0;
      chk("rr_valid", mem_req_valid, 1);
      chk("rr_id", mem_req_id, 64'(i));
      chk("rr_addr", mem_req_addr, 64'(32'h1000_0000 + 32'(i * 16)));
    end
    tick;
    chk("rr_drain", mem_req_valid, 0);
    // FIFO full: read from requester 1 waits for a return
    req_valid = 4'b0010;
    #1 chk("full_noack", req_ack, 0);
    tick;
    #1 chk("full_noack2", req_ack, 0);
    chk("full_slot_empty", mem_req_valid, 0);
    mem_rd_valid = 1'b1;
    mem_rd_data = 32'hAAAA_5555;
    #1 chk("full_pop_ack", req_ack, 4'b0010);
    chk("full_pop_rdv", rd_valid, 4'b0001);
    chk("full_pop_data", rd_data, 32'hAAAA_5555);
    tick;
    req_valid = 4'h0;
    mem_rd_valid = 1'b0;
    chk("full_cap_valid", mem_req_valid, 1);
    chk("full_cap_id", mem_req_id, 1);
    tick;
    exp_rd = '{4'b0010, 4'b0100, 4'b1000, 4'b0010};
    for (int i = 0; i < 4; i++) begin
      mem_rd_valid = 1'b1;
      mem_rd_data = 32'h100 + 32'(i);
      #1 chk("drain_rdv", rd_valid, 64'(exp_rd[i]));
      chk("drain_data", rd_data, 64'(32'h100 + 32'(i)));
      tick;
    end
    mem_rd_valid = 1'b0;
    #1 chk("drain_perr", protocol_error, 0);
    // reads from 3 then 0, returns routed in order
    req_valid = 4'b1000;
    #1 chk("ord_ack3", req_ack, 4'b1000);
    tick;
    chk("ord_id3", mem_req_id, 3);
    req_valid = 4'b0001;
    #1 chk("ord_ack0", req_ack, 4'b0001);
    tick;
    chk("ord_id0", mem_req_id, 0);
    req_valid = 4'h0;
    tick;
    mem_rd_valid = 1'b1;
    mem_rd_data = 32'hDEAD_BEEF;
    #1 chk("ord_rdv3", rd_valid, 4'b1000);
    chk("ord_data3", rd_data, 32'hDEAD_BEEF);
    tick;
    mem_rd_data = 32'h1234_5678;
    #1 chk("ord_rdv0", rd_valid, 4'b0001);
    chk("ord_data0", rd_data, 32'h1234_5678);
    tick;
    mem_rd_valid = 1'b0;
    // a write pushes no id
    req_valid = 4'b0100;
    req_rnw = 4'h0;
    req_addr[2] = 32'h0000_0040;
    req_wdata[2] = 32'hCAFE_F00D;
    #1 chk("wr_ack", req_ack, 4'b0100);
    tick;
    req_valid = 4'h0;
    chk("wr_rnw", mem_req_rnw, 0);
    chk("wr_data", mem_req_wdata, 32'hCAFE_F00D);
    chk("wr_id", mem_req_id, 2);
    tick;
    // unexpected return
    mem_rd_valid = 1'b1;
    #1 chk("perr_rdv", rd_valid, 0);
    tick;
    mem_rd_valid = 1'b0;
    chk("perr_set", protocol_error, 1);
    tick;
    chk("perr_sticky", protocol_error, 1);
    // stall: fields held, no new ack
    mem_req_ready = 1'b0;
    req_valid = 4'b0100;
    req_rnw = 4'b0100;
    req_addr[2] = 32'h8000_0010;
    #1 chk("stall_ack", req_ack, 4'b0100);
    tick;
    req_valid = 4'b0001;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick;
      #1 chk("stall_noack", req_ack, 0);
      chk("stall_valid", mem_req_valid, 1);
      chk("stall_addr", mem_req_addr, 32'h8000_0010);
      chk("stall_id", mem_req_id, 2);
      chk("stall_rnw", mem_req_rnw, 1);
    end
    mem_req_ready = 1'b1;
    #1 chk("stall_release_ack", req_ack, 4'b0001);
    // asynchronous reset with the slot full
    rst = 1'b1;
    #1 chk("arst_valid", mem_req_valid, 0);
    chk("arst_ack", req_ack, 0);
    chk("arst_perr", protocol_error, 0);
    tick;
    rst = 1'b0;
    req_valid = 4'hF;
    req_rnw = 4'h0;
    #1 chk("arst_rr_ack", req_ack, 4'b0001);
    tick;
    req_valid = 4'h0;
    chk("arst_rr_id", mem_req_id, 0);
    mem_rd_valid = 1'b1;
    #1 chk("arst_stale_rdv", rd_valid, 0);
    tick;
    mem_rd_valid = 1'b0;
    chk("arst_stale_perr", protocol_error, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/l1_request_arbiter.md
L1_REQUEST_ARBITER -- requirements
Module: l1_request_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters (fetch icache, dcache, itlb, dtlb).
REQ-002 SHALL have parameter RD_DEPTH, default 4: max outstanding reads; power of 2.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester request pending.
REQ-006 SHALL have port req_addr  input  NUM_REQ x 32  per-requester physical address.
REQ-007 SHALL have port req_rnw  input  NUM_REQ  1 = read, 0 = write.
REQ-008 SHALL have port req_wdata  input  NUM_REQ x 32  write data.
REQ-009 SHALL have port req_ack  output  NUM_REQ  one-hot; request captured this cycle.
REQ-010 SHALL have port mem_req_valid  output  1  registered request to L2/memory.
REQ-011 SHALL have ports mem_req_addr (32), mem_req_rnw (1), mem_req_wdata (32), mem_req_id (clog2 NUM_REQ): outputs, registered request fields.
REQ-012 SHALL have port mem_req_ready  input  1  memory accepts request when high with mem_req_valid.
REQ-013 SHALL have ports mem_rd_valid (1) and mem_rd_data (32): inputs, in-order read return.
REQ-014 SHALL have ports rd_valid (NUM_REQ, one-hot) and rd_data (32): outputs, combinational routing of the read return.
REQ-015 SHALL have port protocol_error  output  1  sticky: read return with no outstanding read.

Function
REQ-016 SHALL hold one output slot; states EMPTY (mem_req_valid=0) and FULL (mem_req_valid=1).
REQ-017 SHALL capture a request when the slot is EMPTY, or FULL and mem_req_ready=1 in the same cycle (back-to-back, zero bubble).
REQ-018 SHALL make requester i eligible when req_valid[i]=1 and (req_rnw[i]=0 or read-ID FIFO not full after this cycle's pop).
REQ-019 SHALL select among eligible requesters round-robin: search starts at rr_ptr; after capture from i, rr_ptr <= (i+1) mod NUM_REQ.
REQ-020 SHALL assert req_ack[i] combinationally in the capture cycle only; requester drops or changes req_valid next cycle.
REQ-021 SHALL keep mem_req_* stable while mem_req_valid=1 and mem_req_ready=0.
REQ-022 SHALL push the requester id into the read-ID FIFO at capture of a read; writes push nothing.
REQ-023 SHALL, on mem_rd_valid with FIFO non-empty, pop the FIFO head h, drive rd_valid[h]=1 and rd_data=mem_rd_data the same cycle.
REQ-024 SHALL allow simultaneous push and pop when the FIFO is full; count stays RD_DEPTH.
REQ-025 SHALL, on mem_rd_valid with FIFO empty, drive rd_valid=0 and set protocol_error until reset.
REQ-026 SHALL transition FULL->EMPTY on handshake with no capture; EMPTY->FULL on capture.

Reset
REQ-027 SHALL, on rst, immediately clear mem_req_valid, req_ack, rd_valid, protocol_error, FIFO count/pointers; rr_ptr <= 0.
REQ-028 SHALL discard any in-flight request and outstanding read IDs on mid-operation reset; returns after reset count as protocol errors.
REQ-029 SHALL not reset data registers (mem_req_addr, mem_req_wdata, FIFO storage).

Structure
REQ-030 SHALL place NUM_L1_REQUESTERS, L1_ID_W and the l1_mem_req_t struct (addr, rnw, wdata, id) in riscv_types.
REQ-031 SHALL instantiate one sub-module, l1_id_fifo (parameterised depth/width, full/empty/count outputs).

Verification
REQ-032 SHALL check: all four reads asserted, mem_req_ready=1 -> grants in order 0,1,2,3, one per cycle, ids 0..3 on mem_req_id.
REQ-033 SHALL check: requester 2 reading at 0x8000_0010, mem_req_ready=0 for 3 cycles -> fields held stable 4 cycles, no new req_ack.
REQ-034 SHALL check: 4 reads outstanding, requester 1 read pending -> no ack until mem_rd_valid; then ack in that same cycle.
REQ-035 SHALL check: reads from ids 3,0 then returns 0xDEAD_BEEF, 0x1234_5678 -> rd_valid=4'b1000 then 4'b0001 with matching data.
REQ-036 SHALL check: mem_rd_valid with empty FIFO -> rd_valid=0, protocol_error=1 until rst.
REQ-037 SHALL check: rst asserted mid-transfer with slot FULL -> mem_req_valid=0 without waiting for a clock edge, rr_ptr=0.
